// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared owner encoding, display symbol codes and symbol
//               mapping helpers for the seven-segment scan arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Display owner; the encoding is visible on the owner port
    typedef enum logic [1:0] {
        OWN_SPEED = 2'd0,
        OWN_ANIM  = 2'd1,
        OWN_ALERT = 2'd2
    } owner_e;

    // Symbols 0..15 are hex digits, 16..22 light single segments a..g
    localparam logic [4:0] SYM_SEG_A = 5'd16;
    localparam logic [4:0] SYM_DASH  = 5'd23;
    localparam logic [4:0] SYM_BLANK = 5'd31;

    localparam logic [2:0] ANIM_MAX  = 3'd6;
    localparam logic [3:0] BCD_MAX   = 4'd9;

    // Animation phase to single-segment symbol; out-of-range phases show a dash
    function automatic logic [4:0] anim_sym(input logic [2:0] q);
        if (q > ANIM_MAX)
            return SYM_DASH;
        return SYM_SEG_A + {2'b00, q};
    endfunction

    // BCD nibble to digit symbol; non-decimal nibbles show a dash
    function automatic logic [4:0] bcd_sym(input logic [3:0] n);
        if (n > BCD_MAX)
            return SYM_DASH;
        return {1'b0, n};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_timer
// Description : Digit slot divider and digit index for the multiplexed scan.
//               Flags the blanking window, the last cycle of each slot and
//               the last cycle of each frame (index wrapping 3 -> 0).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_timer #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       blank,
    output logic [1:0] idx,
    output logic       slot_end,
    output logic       frame_done
);

    localparam int                 c_DIV_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_BLANK_END = c_DIV_W'(BLANK_CYC);
    localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);

    logic [c_DIV_W-1:0] r_div;
    logic [1:0]         r_idx;

    // Slot divider; the digit index advances on the last cycle of each slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (slot_end) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + c_DIV_ONE;
        end
    end

    assign slot_end   = (r_div == c_DIV_LAST);
    assign frame_done = slot_end && (r_idx == 2'd3);
    assign blank      = (r_div < c_BLANK_END);
    assign idx        = r_idx;

endmodule
`default_nettype wire

// File: rtl/ssd_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_arbiter
// Description : Chooses per frame which source owns the 4-digit display
//               (speed, animation or timed alert), snapshots that source into
//               a frame buffer at the frame boundary and scans it out with a
//               blanking gap at the start of every digit slot.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_arbiter
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int BLANK_CYC  = 16,
    parameter int ALERT_HOLD = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  drive,
    input  logic [11:0] anim_q,
    input  logic [15:0] spd_bcd,
    input  logic        alert_req,
    input  logic [15:0] alert_code,
    output logic        alert_ack,
    output logic [1:0]  owner,
    output logic [4:0]  digit_sym,
    output logic [3:0]  ssd_ctrl,
    output logic        frame_done
);

    localparam int                  c_HOLD_W    = $clog2(ALERT_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LOAD = c_HOLD_W'(ALERT_HOLD);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    logic                w_blank;
    logic [1:0]          w_idx;
    logic                w_slot_end;
    logic                w_frame_wrap;
    logic                w_boundary;

    owner_e              r_owner;
    owner_e              w_owner_nxt;
    owner_e              w_drive_owner;
    logic [c_HOLD_W-1:0] r_hold;
    logic [c_HOLD_W-1:0] w_hold_nxt;
    logic                w_take;
    logic                w_expire;

    logic                r_pending;
    logic [15:0]         r_pend_code;
    logic [15:0]         r_alert_code;
    logic [15:0]         w_code;

    logic [3:0][4:0]     r_fbuf;
    logic [3:0][4:0]     w_fbuf_nxt;
    logic [3:0][4:0]     w_anim_sym;
    logic [3:0][4:0]     w_spd_sym;
    logic [3:0][4:0]     w_spd_buf;
    logic [3:0][4:0]     w_code_sym;
    logic                w_lead;

    logic                r_alert_ack;
    logic                r_frame_done;
    logic [3:0]          r_ssd_ctrl;
    logic [4:0]          r_digit_sym;

    ssd_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .blank      (w_blank),
        .idx        (w_idx),
        .slot_end   (w_slot_end),
        .frame_done (w_frame_wrap)
    );

    // The frame boundary is the last cycle of the last slot
    assign w_boundary    = w_slot_end && w_frame_wrap;
    assign w_drive_owner = (drive == 2'b01 || drive == 2'b10) ? OWN_ANIM : OWN_SPEED;
    assign w_expire      = (r_owner == OWN_ALERT) && (r_hold <= c_HOLD_ONE);
    // A newly accepted alert is shown from its pending code in the same refill
    assign w_code        = w_take ? r_pend_code : r_alert_code;

    // Owner state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_SPEED;
            r_hold  <= '0;
        end else begin
            r_owner <= w_owner_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // Owner next-state: pending alert first, then remaining hold, then drive
    always_comb begin
        w_owner_nxt = r_owner;
        w_hold_nxt  = r_hold;
        w_take      = 1'b0;
        if (w_boundary) begin
            if (r_pending && (r_owner != OWN_ALERT || w_expire)) begin
                w_owner_nxt = OWN_ALERT;
                w_hold_nxt  = c_HOLD_LOAD;
                w_take      = 1'b1;
            end else if (r_owner == OWN_ALERT && !w_expire) begin
                w_hold_nxt  = r_hold - c_HOLD_ONE;
            end else begin
                w_owner_nxt = w_drive_owner;
                w_hold_nxt  = '0;
            end
        end
    end

    // Alert capture; a request always wins over the clear from acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_pend_code  <= 16'h0000;
            r_alert_code <= 16'h0000;
        end else begin
            if (alert_req) begin
                r_pending   <= 1'b1;
                r_pend_code <= alert_code;
            end else if (w_take) begin
                r_pending   <= 1'b0;
            end
            if (w_take)
                r_alert_code <= r_pend_code;
        end
    end

    // Per-digit symbol mapping for each source
    for (genvar i = 0; i < 4; i++) begin : g_digit
        assign w_anim_sym[i] = anim_sym(anim_q[3*i +: 3]);
        assign w_spd_sym[i]  = bcd_sym(spd_bcd[4*i +: 4]);
        assign w_code_sym[i] = {1'b0, w_code[4*i +: 4]};
    end

    // Leading-zero blanking of the speed readout; digit 0 is always shown
    always_comb begin
        w_spd_buf = w_spd_sym;
        w_lead    = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (w_lead && spd_bcd[4*i +: 4] == 4'd0)
                w_spd_buf[i] = SYM_BLANK;
            else
                w_lead = 1'b0;
        end
    end

    // Frame buffer contents for the owner that takes the next frame
    always_comb begin
        w_fbuf_nxt = w_spd_buf;
        case (w_owner_nxt)
            OWN_ALERT: w_fbuf_nxt = w_code_sym;
            OWN_ANIM:  w_fbuf_nxt = w_anim_sym;
            default:   w_fbuf_nxt = w_spd_buf;
        endcase
    end

    // Frame buffer refilled only at the boundary so a frame never tears
    always_ff @(posedge clk) begin
        if (rst)
            r_fbuf <= {4{SYM_BLANK}};
        else if (w_boundary)
            r_fbuf <= w_fbuf_nxt;
    end

    // Registered scan outputs and boundary pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ssd_ctrl   <= 4'b1111;
            r_digit_sym  <= SYM_BLANK;
            r_alert_ack  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_alert_ack  <= w_take;
            r_frame_done <= w_boundary;
            if (w_blank) begin
                r_ssd_ctrl  <= 4'b1111;
                r_digit_sym <= SYM_BLANK;
            end else begin
                r_ssd_ctrl  <= ~(4'b0001 << w_idx);
                r_digit_sym <= r_fbuf[w_idx];
            end
        end
    end

    assign owner      = r_owner;
    assign alert_ack  = r_alert_ack;
    assign frame_done = r_frame_done;
    assign ssd_ctrl   = r_ssd_ctrl;
    assign digit_sym  = r_digit_sym;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_arbiter
// Description : Directed self-checking bench for ssd_scan_arbiter with
//               SCAN_DIV=8, BLANK_CYC=2, ALERT_HOLD=3 (32-cycle frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_arbiter;

    localparam int c_SCAN_DIV   = 8;
    localparam int c_BLANK_CYC  = 2;
    localparam int c_ALERT_HOLD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  drive = 2'b00;
    logic [11:0] anim_q = 12'h000;
    logic [15:0] spd_bcd = 16'h0000;
    logic        alert_req = 1'b0;
    logic [15:0] alert_code = 16'h0000;
    logic        alert_ack;
    logic [1:0]  owner;
    logic [4:0]  digit_sym;
    logic [3:0]  ssd_ctrl;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    ssd_scan_arbiter #(
        .SCAN_DIV   (c_SCAN_DIV),
        .BLANK_CYC  (c_BLANK_CYC),
        .ALERT_HOLD (c_ALERT_HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .drive      (drive),
        .anim_q     (anim_q),
        .spd_bcd    (spd_bcd),
        .alert_req  (alert_req),
        .alert_code (alert_code),
        .alert_ack  (alert_ack),
        .owner      (owner),
        .digit_sym  (digit_sym),
        .ssd_ctrl   (ssd_ctrl),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance to the next frame_done pulse, bounded by slightly over one frame
    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        chk("frame_done_seen", {31'd0, frame_done}, 32'd1);
    endtask

    // From a frame_done sample point, check each digit's first lit cycle
    task automatic check_frame(input string tag, input logic [4:0] s0, input logic [4:0] s1,
                               input logic [4:0] s2, input logic [4:0] s3);
        cyc(3);
        chk({tag, "_ctrl0"}, {28'd0, ssd_ctrl}, 32'he);
        chk({tag, "_sym0"}, {27'd0, digit_sym}, {27'd0, s0});
        cyc(8);
        chk({tag, "_ctrl1"}, {28'd0, ssd_ctrl}, 32'hd);
        chk({tag, "_sym1"}, {27'd0, digit_sym}, {27'd0, s1});
        cyc(8);
        chk({tag, "_ctrl2"}, {28'd0, ssd_ctrl}, 32'hb);
        chk({tag, "_sym2"}, {27'd0, digit_sym}, {27'd0, s2});
        cyc(8);
        chk({tag, "_ctrl3"}, {28'd0, ssd_ctrl}, 32'h7);
        chk({tag, "_sym3"}, {27'd0, digit_sym}, {27'd0, s3});
    endtask

    task automatic pulse_req(input logic [15:0] code);
        alert_req  = 1'b1;
        alert_code = code;
        cyc(1);
        alert_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack_cnt;
        int fd_cnt;

        // Reset values
        cyc(3);
        chk("rst_ctrl", {28'd0, ssd_ctrl}, 32'hf);
        chk("rst_sym", {27'd0, digit_sym}, 32'd31);
        chk("rst_owner", {30'd0, owner}, 32'd0);
        chk("rst_ack", {31'd0, alert_ack}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // 1. First frame: scan pattern, frame_done on cycle 32, all blank
        for (int m = 1; m <= 32; m++) begin
            int d;
            int x;
            logic [3:0] e_ctrl;
            cyc(1);
            d = (m - 1) % 8;
            x = (m - 1) / 8;
            e_ctrl = (d < 2) ? 4'b1111 : ~(4'b0001 << x);
            chk("scan_ctrl", {28'd0, ssd_ctrl}, {28'd0, e_ctrl});
            chk("scan_sym", {27'd0, digit_sym}, 32'd31);
            chk("scan_fd", {31'd0, frame_done}, (m == 32) ? 32'd1 : 32'd0);
        end
        chk("t1_owner", {30'd0, owner}, 32'd0);
        check_frame("t1_spd0", 5'd0, 5'd31, 5'd31, 5'd31);

        // 2. Speed readout with leading-zero blanking and invalid nibble
        spd_bcd = 16'h0402;
        wait_frame();
        check_frame("t2_0402", 5'd2, 5'd0, 5'd4, 5'd31);
        spd_bcd = 16'h00A1;
        wait_frame();
        check_frame("t2_00a1", 5'd1, 5'd23, 5'd31, 5'd31);

        // 3. Animation, and a mid-frame input change that must not tear
        drive  = 2'b01;
        anim_q = {3'd3, 3'd2, 3'd1, 3'd0};
        wait_frame();
        chk("t3_owner", {30'd0, owner}, 32'd1);
        cyc(3);
        chk("t3_sym0", {27'd0, digit_sym}, 32'd16);
        anim_q = {3'd7, 3'd6, 3'd5, 3'd4};
        cyc(8);
        chk("t3_sym1", {27'd0, digit_sym}, 32'd17);
        cyc(8);
        chk("t3_sym2", {27'd0, digit_sym}, 32'd18);
        cyc(8);
        chk("t3_sym3", {27'd0, digit_sym}, 32'd19);
        wait_frame();
        check_frame("t3_new", 5'd20, 5'd21, 5'd22, 5'd23);

        // 4. Alert E0F1 held exactly 3 frames
        pulse_req(16'hE0F1);
        wait_frame();
        chk("t4_ack", {31'd0, alert_ack}, 32'd1);
        chk("t4_owner", {30'd0, owner}, 32'd2);
        check_frame("t4_f1", 5'd1, 5'd15, 5'd0, 5'd14);
        wait_frame();
        chk("t4_ack2", {31'd0, alert_ack}, 32'd0);
        chk("t4_owner2", {30'd0, owner}, 32'd2);
        check_frame("t4_f2", 5'd1, 5'd15, 5'd0, 5'd14);
        wait_frame();
        chk("t4_owner3", {30'd0, owner}, 32'd2);
        check_frame("t4_f3", 5'd1, 5'd15, 5'd0, 5'd14);
        wait_frame();
        chk("t4_owner_end", {30'd0, owner}, 32'd1);
        chk("t4_ack_end", {31'd0, alert_ack}, 32'd0);
        check_frame("t4_anim", 5'd20, 5'd21, 5'd22, 5'd23);

        // 5. Requests during hold: latest wins, shown after expiry, one ack
        pulse_req(16'h1111);
        wait_frame();
        chk("t5_ack1", {31'd0, alert_ack}, 32'd1);
        cyc(3);
        pulse_req(16'h2222);
        cyc(4);
        pulse_req(16'h3333);
        wait_frame();
        chk("t5_ack_b2", {31'd0, alert_ack}, 32'd0);
        chk("t5_owner_b2", {30'd0, owner}, 32'd2);
        check_frame("t5_ones", 5'd1, 5'd1, 5'd1, 5'd1);
        wait_frame();
        chk("t5_ack_b3", {31'd0, alert_ack}, 32'd0);
        wait_frame();
        chk("t5_ack_b4", {31'd0, alert_ack}, 32'd1);
        chk("t5_owner_b4", {30'd0, owner}, 32'd2);
        check_frame("t5_threes", 5'd3, 5'd3, 5'd3, 5'd3);
        wait_frame();
        chk("t5_ack_b5", {31'd0, alert_ack}, 32'd0);
        wait_frame();
        chk("t5_ack_b6", {31'd0, alert_ack}, 32'd0);
        chk("t5_owner_b6", {30'd0, owner}, 32'd2);
        check_frame("t5_threes3", 5'd3, 5'd3, 5'd3, 5'd3);
        wait_frame();
        chk("t5_owner_b7", {30'd0, owner}, 32'd1);
        chk("t5_ack_b7", {31'd0, alert_ack}, 32'd0);

        // drive=11 counts as stopped
        drive = 2'b11;
        wait_frame();
        chk("t5_owner_11", {30'd0, owner}, 32'd0);

        // Request in the boundary cycle is deferred to the following boundary
        cyc(31);
        alert_req  = 1'b1;
        alert_code = 16'h7777;
        cyc(1);
        alert_req  = 1'b0;
        chk("t7_fd", {31'd0, frame_done}, 32'd1);
        chk("t7_ack_defer", {31'd0, alert_ack}, 32'd0);
        chk("t7_owner_defer", {30'd0, owner}, 32'd0);
        wait_frame();
        chk("t7_ack", {31'd0, alert_ack}, 32'd1);
        chk("t7_owner", {30'd0, owner}, 32'd2);
        check_frame("t7_sevens", 5'd7, 5'd7, 5'd7, 5'd7);

        // 6. Reset during alert with a pending request
        pulse_req(16'h5555);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("t6_ctrl", {28'd0, ssd_ctrl}, 32'hf);
        chk("t6_sym", {27'd0, digit_sym}, 32'd31);
        chk("t6_owner", {30'd0, owner}, 32'd0);
        chk("t6_ack", {31'd0, alert_ack}, 32'd0);
        rst = 1'b0;
        ack_cnt = 0;
        fd_cnt  = 0;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            if (alert_ack)  ack_cnt++;
            if (frame_done) fd_cnt++;
        end
        chk("t6_no_ack", ack_cnt, 32'd0);
        chk("t6_frames", fd_cnt, 32'd3);
        chk("t6_owner_after", {30'd0, owner}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
